// File: rtl/bus_write_demux_pkg.sv
// bus_write_demux_pkg: shared destination codes, RUN/HALT encoding and bus width
package bus_write_demux_pkg;
   localparam int WIDTH = 16;
   localparam int SEL_W = 3;
   // Codes 000-100 double as bus-A source selects
   typedef enum logic [2:0] {
      SEL_AC   = 3'b000,
      SEL_AR   = 3'b001,
      SEL_PC   = 3'b010,
      SEL_DR   = 3'b011,
      SEL_TR   = 3'b100,
      SEL_DIS0 = 3'b101,
      SEL_END  = 3'b110,
      SEL_DIS1 = 3'b111
   } sel_e;
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;
endpackage

// File: rtl/bus_write_hold.sv
// bus_write_hold: one-entry hold register (valid/sel/data) plus the END-pending flag
module bus_write_hold #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             acc,
   input  logic [SEL_W-1:0] sel_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             valid,
   output logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] data,
   output logic             hold_end
);
   import bus_write_demux_pkg::*;
   logic             valid_q, valid_d, end_q, end_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   // Entry drains every cycle, so it holds exactly what was accepted on the last edge
   always_comb begin
      valid_d = acc;
      end_d   = acc && (sel_in == SEL_END);
      sel_d   = acc ? sel_in : sel_q;
      data_d  = acc ? data_in : data_q;
   end
   // Hold state; reset drops any pending entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         end_q   <= end_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
      end
   end
   assign valid    = valid_q;
   assign sel      = sel_q;
   assign data     = data_q;
   assign hold_end = end_q;
endmodule

// File: rtl/bus_write_demux.sv
// bus_write_demux: bus destination register bank with RUN/HALT FSM; BUS_WRITE_TRACE_EN adds commit trace outputs
module bus_write_demux #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEL_W-1:0] wr_sel,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             inc_pc,
   input  logic             inc_ar,
   input  logic             clr_ac,
   input  logic             resume,
   output logic [WIDTH-1:0] AC,
   output logic [WIDTH-1:0] AR,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] DR,
   output logic [WIDTH-1:0] TR,
   output logic             wr_done,
`ifdef BUS_WRITE_TRACE_EN
   output logic [SEL_W-1:0] last_sel,
   output logic [WIDTH-1:0] last_data,
   output logic [15:0]      wr_count,
`endif
   output logic             halted
);
   import bus_write_demux_pkg::*;
   state_e           state_q, state_d;
   logic             acc, run, h_valid, h_end;
   logic [SEL_W-1:0] h_sel;
   logic [WIDTH-1:0] h_data;
   logic [WIDTH-1:0] ac_q, ac_d, ar_q, ar_d, pc_q, pc_d, dr_q, dr_d, tr_q, tr_d;
   logic             done_q, done_d;

   bus_write_hold #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .acc      (acc),
      .sel_in   (wr_sel),
      .data_in  (bus_in),
      .valid    (h_valid),
      .sel      (h_sel),
      .data     (h_data),
      .hold_end (h_end)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end
   // Next state: committed END halts, resume leaves HALT
   always_comb begin
      state_d = state_q;
      if (h_valid && h_sel == SEL_END) state_d = ST_HALT;
      else if (state_q == ST_HALT && resume) state_d = ST_RUN;
   end
   // FSM outputs: ready drops as soon as END is held so nothing follows it
   always_comb begin
      run      = (state_q == ST_RUN);
      wr_ready = run && !h_end;
      acc      = wr_valid && wr_ready;
      halted   = (state_q == ST_HALT);
   end

   // Register bank next values: commit beats clear beats increment
   always_comb begin
      ac_d   = (h_valid && h_sel == SEL_AC) ? h_data : (run && clr_ac) ? '0 : ac_q;
      ar_d   = (h_valid && h_sel == SEL_AR) ? h_data : (run && inc_ar) ? ar_q + 1'b1 : ar_q;
      pc_d   = (h_valid && h_sel == SEL_PC) ? h_data : (run && inc_pc) ? pc_q + 1'b1 : pc_q;
      dr_d   = (h_valid && h_sel == SEL_DR) ? h_data : dr_q;
      tr_d   = (h_valid && h_sel == SEL_TR) ? h_data : tr_q;
      done_d = h_valid;
   end
   // Register bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ac_q   <= '0;
         ar_q   <= '0;
         pc_q   <= '0;
         dr_q   <= '0;
         tr_q   <= '0;
         done_q <= 1'b0;
      end else begin
         ac_q   <= ac_d;
         ar_q   <= ar_d;
         pc_q   <= pc_d;
         dr_q   <= dr_d;
         tr_q   <= tr_d;
         done_q <= done_d;
      end
   end
   assign AC      = ac_q;
   assign AR      = ar_q;
   assign PC      = pc_q;
   assign DR      = dr_q;
   assign TR      = tr_q;
   assign wr_done = done_q;

`ifdef BUS_WRITE_TRACE_EN
   logic [SEL_W-1:0] last_sel_q, last_sel_d;
   logic [WIDTH-1:0] last_data_q, last_data_d;
   logic [15:0]      wr_count_q, wr_count_d;
   // Trace next values: capture every commit, count wraps
   always_comb begin
      last_sel_d  = h_valid ? h_sel : last_sel_q;
      last_data_d = h_valid ? h_data : last_data_q;
      wr_count_d  = h_valid ? wr_count_q + 16'd1 : wr_count_q;
   end
   // Trace registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_sel_q  <= '0;
         last_data_q <= '0;
         wr_count_q  <= '0;
      end else begin
         last_sel_q  <= last_sel_d;
         last_data_q <= last_data_d;
         wr_count_q  <= wr_count_d;
      end
   end
   assign last_sel  = last_sel_q;
   assign last_data = last_data_q;
   assign wr_count  = wr_count_q;
`endif
endmodule

// File: tb/tb_bus_write_demux.sv
// tb_bus_write_demux: directed table, reset corner case and random run against a transfer-queue model
module tb_bus_write_demux;
   logic        clk = 1'b0, reset = 1'b1;
   logic [2:0]  wr_sel = '0;
   logic        wr_valid = 1'b0, inc_pc = 1'b0, inc_ar = 1'b0, clr_ac = 1'b0, resume = 1'b0;
   logic [15:0] bus_in = '0;
   logic        wr_ready, wr_done, halted;
   logic [15:0] AC, AR, PC, DR, TR;
`ifdef BUS_WRITE_TRACE_EN
   logic [2:0]  last_sel;
   logic [15:0] last_data, wr_count;
`endif

   bus_write_demux dut (
      .clk(clk), .reset(reset), .wr_sel(wr_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .bus_in(bus_in), .inc_pc(inc_pc), .inc_ar(inc_ar), .clr_ac(clr_ac), .resume(resume),
      .AC(AC), .AR(AR), .PC(PC), .DR(DR), .TR(TR), .wr_done(wr_done),
`ifdef BUS_WRITE_TRACE_EN
      .last_sel(last_sel), .last_data(last_data), .wr_count(wr_count),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   int nvec = 0, nerr = 0;

   task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // Reference model: register file, halt flag and a queue of accepted-but-uncommitted transfers
   typedef struct { logic [2:0] sel; logic [15:0] data; } xfer_t;
   xfer_t       pq[$];
   logic [15:0] m_reg [5];
   logic        m_halt = 1'b0, m_done = 1'b0;
   string       rn [5] = '{"AC", "AR", "PC", "DR", "TR"};

   function automatic logic model_ready();
      return !m_halt && !(pq.size() > 0 && pq[0].sel == 3'b110);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_reg[i] = '0;
      pq.delete();
      m_halt = 1'b0;
      m_done = 1'b0;
   endtask

   task automatic check_all();
      logic [15:0] act [5];
      act = '{AC, AR, PC, DR, TR};
      for (int i = 0; i < 5; i++) chk(rn[i], act[i], m_reg[i]);
      chk("wr_done", {15'd0, wr_done}, {15'd0, m_done});
      chk("halted", {15'd0, halted}, {15'd0, m_halt});
      chk("wr_ready", {15'd0, wr_ready}, {15'd0, model_ready()});
   endtask

   // One clock: predict from the driven inputs, advance, compare
   task automatic step();
      logic [15:0] nxt [5];
      logic        nh, rdy;
      xfer_t       t;
      rdy = model_ready();
      chk("wr_ready_pre", {15'd0, wr_ready}, {15'd0, rdy});
      nxt = m_reg;
      nh = m_halt;
      m_done = 1'b0;
      if (!m_halt) begin
         if (clr_ac) nxt[0] = 16'h0000;
         if (inc_ar) nxt[1] = m_reg[1] + 16'd1;
         if (inc_pc) nxt[2] = m_reg[2] + 16'd1;
      end else if (resume) nh = 1'b0;
      if (pq.size() > 0) begin
         t = pq.pop_front();
         m_done = 1'b1;
         if (t.sel <= 3'd4) nxt[t.sel] = t.data;
         else if (t.sel == 3'b110) nh = 1'b1;
      end
      if (wr_valid && rdy) begin
         t.sel = wr_sel;
         t.data = bus_in;
         pq.push_back(t);
      end
      @(posedge clk);
      #1;
      m_reg = nxt;
      m_halt = nh;
      check_all();
   endtask

   typedef struct {
      logic v; logic [2:0] sel; logic [15:0] data;
      logic ipc, iar, cac, res;
      int ri; logic [15:0] rv; logic dn, hl, rd;
   } vec_t;
   vec_t tbl [24];

   initial begin
      logic [15:0] act [5];
      tbl[0]  = '{1'b1, 3'b000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 3'b011, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1234, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 16'hABCD, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 16'hABCD, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 3'b010, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 16'hFFFF, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 3'b000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 3'b000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 16'h0001, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 3'b010, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 2, 16'h0001, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 3'b000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 2, 16'h0040, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 3'b000, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h1234, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h7777, 1'b1, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h7777, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 3'b101, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h7777, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 16'hABCD, 1'b1, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[16] = '{1'b1, 3'b100, 16'h0BAD, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 3'b110, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 16'h0BAD, 1'b1, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 3'b000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 2, 16'h0040, 1'b1, 1'b1, 1'b0};
      tbl[19] = '{1'b1, 3'b000, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 2, 16'h0040, 1'b0, 1'b1, 1'b0};
      tbl[20] = '{1'b1, 3'b000, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 0, 16'h7777, 1'b0, 1'b1, 1'b0};
      tbl[21] = '{1'b1, 3'b000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 0, 16'h7777, 1'b0, 1'b0, 1'b1};
      tbl[22] = '{1'b1, 3'b000, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h7777, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{1'b0, 3'b000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h5555, 1'b1, 1'b0, 1'b1};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      #1;
      chk("ready_after_reset", {15'd0, wr_ready}, 16'd1);

      for (int i = 0; i < 24; i++) begin
         wr_valid = tbl[i].v; wr_sel = tbl[i].sel; bus_in = tbl[i].data;
         inc_pc = tbl[i].ipc; inc_ar = tbl[i].iar; clr_ac = tbl[i].cac; resume = tbl[i].res;
         step();
         act = '{AC, AR, PC, DR, TR};
         chk($sformatf("tbl%0d_%s", i, rn[tbl[i].ri]), act[tbl[i].ri], tbl[i].rv);
         chk($sformatf("tbl%0d_done", i), {15'd0, wr_done}, {15'd0, tbl[i].dn});
         chk($sformatf("tbl%0d_halted", i), {15'd0, halted}, {15'd0, tbl[i].hl});
         chk($sformatf("tbl%0d_ready", i), {15'd0, wr_ready}, {15'd0, tbl[i].rd});
      end

      // Reset lands between accept and commit: the AR write must never appear
      wr_valid = 1'b1; wr_sel = 3'b001; bus_in = 16'h0F0F;
      inc_pc = 1'b0; inc_ar = 1'b0; clr_ac = 1'b0; resume = 1'b0;
      step();
      wr_valid = 1'b0;
      reset = 1'b1;
      #2;
      chk("rst_async_AC", AC, 16'h0000);
      chk("rst_async_halted", {15'd0, halted}, 16'd0);
      @(posedge clk);
      #1;
      chk("rst_AR", AR, 16'h0000);
      chk("rst_done", {15'd0, wr_done}, 16'd0);
      reset = 1'b0;
      model_reset();
      step();
      chk("post_rst_AR", AR, 16'h0000);
      chk("post_rst_done", {15'd0, wr_done}, 16'd0);

      for (int i = 0; i < 1500; i++) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_sel = 3'($urandom_range(0, 7));
         if (wr_sel == 3'b110 && $urandom_range(0, 3) != 0) wr_sel = 3'b001;
         bus_in = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         inc_pc = ($urandom_range(0, 3) == 0);
         inc_ar = ($urandom_range(0, 3) == 0);
         clr_ac = ($urandom_range(0, 5) == 0);
         resume = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/bus_write_demux.md
# bus_write_demux

Destination end of the processor's 16-bit internal bus. It captures a bus word with a valid/ready handshake and, one cycle later, commits it into one of the five architectural registers: AC, AR, PC, DR or TR. It also applies PC/AR increment and AC clear micro-operations. It latches the end-of-operations code into a halt state. It sits between the ALU/bus output and the register outputs that feed the bus-A source multiplexer.

## Interface
Parameters:
- WIDTH, 16, bus and register width
- SEL_W, 3, destination select width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- wr_sel  in  3  destination code: 000 AC, 001 AR, 010 PC, 011 DR, 100 TR, 110 END, 101/111 discard
- wr_valid  in  1  bus word and select are valid
- wr_ready  out  1  block can accept a transfer
- bus_in  in  WIDTH  bus data
- inc_pc  in  1  increment PC
- inc_ar  in  1  increment AR
- clr_ac  in  1  clear AC
- resume  in  1  leave the HALT state
- AC, AR, PC, DR, TR  out  WIDTH  register contents
- wr_done  out  1  one-cycle pulse, a transfer committed
- halted  out  1  block is in the HALT state

## Operation
- Two states: RUN and HALT. Reset puts the block in RUN.
- Handshake: a transfer is accepted on an edge where wr_valid && wr_ready. wr_ready = (state == RUN) && !hold_end.
- Accepted sel/data go into a one-entry hold register. The hold register commits on the next edge.
- The hold register drains every cycle, so RUN sustains one transfer per cycle.
- Commit:
  - Codes 000–100 write the target register.
  - 101/111 are discarded.
  - 110 moves the block to HALT.
  - wr_done pulses for every commit, including discard and END.
- hold_end is set when an END code is accepted. It deasserts wr_ready on the cycle before HALT, so no transfer follows END.
- Micro-operations, in RUN only, applied on the same edge they are sampled:
  - PC+1 and AR+1 wrap modulo 2^WIDTH (FFFF→0000).
  - AC clears to 0.
- Priority on one register in the same edge: commit > clr_ac > increment. The losing micro-operation is dropped, not deferred.
- HALT:
  - wr_ready = 0; inc_pc, inc_ar and clr_ac are ignored; registers hold.
  - resume = 1 moves the block to RUN on the next edge.
  - resume has no effect in RUN.
- Reset asserted mid-transfer: the hold entry is dropped, the block goes to RUN, all registers clear. The pending commit never occurs.

## Timing
- Reset values: AC = AR = PC = DR = TR = 0, wr_done = 0, halted = 0, wr_ready = 1 once reset deasserts.
- Latency: accept at edge N; the register shows the new value after edge N+1; wr_done is high during the cycle after edge N+1.
- A micro-operation sampled at edge N is visible after edge N.
- END accepted at edge N:
  - wr_ready is low after N.
  - halted is high and wr_done pulses after N+1.
- resume sampled at edge M in HALT: halted is low and wr_ready is high after M.
- All outputs are registered except wr_ready, which is decoded from state and hold_end.

## Configuration
- BUS_WRITE_TRACE_EN defined:
  - Adds outputs last_sel (3 bits), last_data (WIDTH) and wr_count (16 bits).
  - All three are updated on each commit; wr_count wraps.
  - All three reset to 0.
- BUS_WRITE_TRACE_EN undefined: these ports and their registers are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the destination codes (AC, AR, PC, DR, TR, END, and the discard codes)
  - the RUN/HALT state encoding
  - WIDTH
- The bus-A source multiplexer uses the same codes 000–100.
- One sub-module: bus_write_hold, the one-entry hold register with valid, sel and data, plus the hold_end flag.
- The register bank, priority logic and FSM stay in the top module.

## Test plan
- Reset, then write sel=000 data=1234, then sel=011 data=ABCD back-to-back → AC=1234 after edge N+1, DR=ABCD one cycle later; wr_done high two consecutive cycles; wr_ready never drops.
- PC=FFFF, inc_pc for 2 cycles → PC=0000, then 0001.
- Commit sel=010 data=0040 on the same edge as inc_pc → PC=0040. Commit sel=000 with clr_ac on the same edge → AC=bus value.
- Send sel=110, then hold wr_valid high with sel=000 data=5555 → halted=1, AC unchanged, inc_pc ignored. resume=1 → RUN; the pending transfer is accepted and AC=5555 one cycle after acceptance.
- sel=101 data=FFFF → no register changes, wr_done pulses once.
- Accept sel=001 data=0F0F, assert reset before the commit edge → AR=0000, wr_done stays 0, halted=0.
